autobaud_ctrl: RTL and testbench

AUTOBAUD_CTRL -- requirements
Module: autobaud_ctrl

---
 rtl/autobaud_pkg.sv | 27 ++
 rtl/autobaud_sync.sv | 21 ++
 rtl/autobaud_ctrl.sv | 113 +++++++++++
 tb/tb_autobaud_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/autobaud_pkg.sv
// autobaud_pkg: rate table, FSM states and timing helpers for the autobaud controller
package autobaud_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_WAIT_FALL,
        S_MEASURE,
        S_LOCKED,
        S_ERROR
    } state_t;

    localparam int BAUD [4] = '{1200, 2400, 4800, 9600};

    function automatic int bit_clks(int clk_freq, int i);
        return clk_freq / BAUD[i];
    endfunction

    function automatic int thresh(int clk_freq, int i);
        return bit_clks(clk_freq, i) * 3 / 4;
    endfunction

    function automatic int tmo_clks(int clk_freq);
        return 2 * bit_clks(clk_freq, 0);
    endfunction

endpackage

// File: rtl/autobaud_sync.sv
// autobaud_sync: multi-flop synchronizer for the serial line, resetting to idle-high
module autobaud_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ff_q <= '1;
        else        ff_q <= STAGES'({ff_q, d_i});
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/autobaud_ctrl.sv
// autobaud_ctrl: measures the first low pulse on rx and selects the matching baud rate
module autobaud_ctrl
    import autobaud_pkg::*;
#(
    parameter int CLK_FREQ  = 576_000,
    parameter int IDLE_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       start,
    output logic [1:0] sel,
    output logic       locked,
    output logic       done,
    output logic       busy,
    output logic       err
);

    localparam int TMO = tmo_clks(CLK_FREQ);
    localparam int CW  = $clog2(TMO + 1);
    localparam logic [CW-1:0] TMO_C  = CW'(TMO);
    localparam logic [CW-1:0] IDLE_C = CW'(IDLE_BITS * bit_clks(CLK_FREQ, 0));
    localparam logic [CW-1:0] TH0    = CW'(thresh(CLK_FREQ, 0));
    localparam logic [CW-1:0] TH1    = CW'(thresh(CLK_FREQ, 1));
    localparam logic [CW-1:0] TH2    = CW'(thresh(CLK_FREQ, 2));
    localparam logic [CW-1:0] TH3    = CW'(thresh(CLK_FREQ, 3));

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_inc;
    logic [1:0]      rate;
    logic            rx_s;

    autobaud_sync #(.STAGES(2)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // saturating increment and classification of the measured low time
    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        rate    = (cnt_q >= TH0) ? 2'd0 : (cnt_q >= TH1) ? 2'd1 : (cnt_q >= TH2) ? 2'd2 : 2'd3;
    end

    // detection FSM with registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel     <= 2'd0;
            locked  <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE, S_LOCKED, S_ERROR: begin
                    if (start) begin
                        state_q <= S_WAIT_IDLE;
                        cnt_q   <= '0;
                        err     <= 1'b0;
                        locked  <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!rx_s) begin
                        cnt_q <= '0;
                    end else if (cnt_inc == IDLE_C) begin
                        state_q <= S_WAIT_FALL;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_WAIT_FALL: begin
                    if (!rx_s) begin
                        state_q <= S_MEASURE;
                        cnt_q   <= CW'(1);
                    end
                end
                S_MEASURE: begin
                    if (!rx_s) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == TMO_C) begin
                            state_q <= S_ERROR;
                            err     <= 1'b1;
                            locked  <= 1'b0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end else if (cnt_q >= TH3) begin
                        state_q <= S_LOCKED;
                        sel     <= rate;
                        locked  <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        state_q <= S_WAIT_FALL;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_autobaud_ctrl.sv
// tb_autobaud_ctrl: directed autobaud scenarios with hand-computed expectations
module tb_autobaud_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       start = 1'b0;
    logic [1:0] sel;
    logic       locked, done, busy, err;
    int         vectors = 0;
    int         miscompares = 0;
    int         done_cnt = 0;
    int         d0;

    autobaud_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .rx     (rx),
        .start  (start),
        .sel    (sel),
        .locked (locked),
        .done   (done),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    // count cycles with done high; a clean pulse adds exactly one
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        cyc(n);
    endtask

    task automatic low(input int n);
        rx = 1'b0;
        cyc(n);
        rx = 1'b1;
        cyc(8);
    endtask

    task automatic detect(input int n, input int exp_sel);
        go();
        idle(500);
        d0 = done_cnt;
        low(n);
        chk($sformatf("done_%0d", n), done_cnt - d0, 1);
        chk($sformatf("sel_%0d", n), sel, exp_sel);
        chk($sformatf("locked_%0d", n), locked, 1);
        chk($sformatf("err_%0d", n), err, 0);
        chk($sformatf("busy_%0d", n), busy, 0);
    endtask

    initial begin
        cyc(3);
        chk("rst_sel", sel, 0);
        chk("rst_locked", locked, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        cyc(2);

        detect(480, 0);
        detect(60, 3);

        go();
        idle(250);
        chk("redet_locked", locked, 0);
        chk("redet_sel", sel, 3);
        chk("redet_busy", busy, 1);
        idle(250);
        d0 = done_cnt;
        low(240);
        chk("redet_done", done_cnt - d0, 1);
        chk("redet_sel_new", sel, 1);

        go();
        idle(500);
        d0 = done_cnt;
        low(30);
        cyc(20);
        chk("glitch_done", done_cnt - d0, 0);
        chk("glitch_busy", busy, 1);
        chk("glitch_sel", sel, 1);
        low(120);
        chk("after_glitch_done", done_cnt - d0, 1);
        chk("after_glitch_sel", sel, 2);

        go();
        idle(500);
        d0 = done_cnt;
        low(44);
        chk("low44_done", done_cnt - d0, 0);
        chk("low44_busy", busy, 1);
        low(45);
        chk("low45_done", done_cnt - d0, 1);
        chk("low45_sel", sel, 3);

        detect(359, 1);
        detect(360, 0);
        detect(179, 2);
        detect(89, 3);

        go();
        idle(500);
        d0 = done_cnt;
        rx = 1'b0;
        cyc(961);
        chk("tmo_pre_err", err, 0);
        chk("tmo_pre_busy", busy, 1);
        cyc(1);
        chk("tmo_err", err, 1);
        chk("tmo_done_lvl", done, 1);
        cyc(38);
        rx = 1'b1;
        cyc(8);
        chk("tmo_done", done_cnt - d0, 1);
        chk("tmo_sel", sel, 3);
        chk("tmo_locked", locked, 0);
        chk("tmo_busy", busy, 0);
        go();
        chk("restart_err", err, 0);
        chk("restart_busy", busy, 1);

        rx = 1'b0;
        cyc(100);
        rx = 1'b1;
        cyc(200);
        go();
        cyc(269);
        d0 = done_cnt;
        low(60);
        chk("unqual_done", done_cnt - d0, 0);
        chk("unqual_busy", busy, 1);
        idle(500);
        rx = 1'b0;
        cyc(30);
        go();
        cyc(89);
        rx = 1'b1;
        cyc(8);
        chk("busy_start_done", done_cnt - d0, 1);
        chk("busy_start_sel", sel, 2);
        chk("busy_start_locked", locked, 1);

        go();
        idle(500);
        rx = 1'b0;
        cyc(200);
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        chk("arst_sel", sel, 0);
        chk("arst_locked", locked, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        cyc(2);
        reset = 1'b1;
        rx = 1'b1;
        cyc(10);
        chk("arst_no_done", done_cnt - d0, 0);
        chk("arst_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
